// File: rtl/logicnet_pkg.sv
// Shared definitions for the LogicNet classifier pipeline control logic.
// Contents:
//   LN_NUM_LAYERS : default number of neuron layers (one register stage each)
//   LN_SAT_W      : widest counter that sat_inc can serve
//   sat_inc       : saturating increment at LN_SAT_W bits. Callers narrow it to
//                   their own width with a local wrapper function.
package logicnet_pkg;

  localparam int LN_NUM_LAYERS = 4;
  localparam int LN_SAT_W      = 32;

  // Counters narrower than LN_SAT_W pass their all-ones value as max_val.
  function automatic logic [LN_SAT_W-1:0] sat_inc(
    input logic [LN_SAT_W-1:0] val,
    input logic [LN_SAT_W-1:0] max_val
  );
    return (val >= max_val) ? max_val : val + LN_SAT_W'(1);
  endfunction

endpackage

// File: rtl/logicnet_stage_slot.sv
// One stage of the elastic pipeline. It holds the valid bit for one layer
// output register and derives that register's load enable.
// Ports:
//   clk, rst  : clock and synchronous active-low reset
//   up_valid  : the upstream stage (or the feature input) holds a sample
//   dn_ready  : the downstream stage (or the consumer) can take a sample
//   flush     : drop the held sample
//   valid     : this stage holds a sample
//   rdy       : this stage can take a sample this cycle (empty, or draining)
//   en        : load enable for the layer register. It fires only on a real sample.
module logicnet_stage_slot
  import logicnet_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic up_valid,
  input  logic dn_ready,
  input  logic flush,
  output logic valid,
  output logic rdy,
  output logic en
);

  logic valid_q;
  logic valid_d;

  assign valid = valid_q;
  assign rdy   = ~valid_q | dn_ready;
  assign en    = rdy & up_valid & ~flush;

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (rdy) begin
      valid_d = up_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/logicnet_pipe_ctrl.sv
// Elastic pipeline controller for the LogicNet classifier datapath.
// The block has one valid-tracking slot per layer register and drives only the
// load enables. The layer LUTs and their data registers live outside this block.
// Ports:
//   clk, rst             : clock and synchronous active-low reset
//   in_valid / in_ready  : feature-vector handshake at the layer0 inputs
//   stage_en             : per-layer output register load enables
//   out_valid / out_ready: class-result handshake at the last layer
//   flush                : discard every in-flight sample
//   cnt_clr              : zero the sample and stall counters
//   inflight             : number of stages holding a sample
//   sample_cnt           : completed output handshakes (saturating)
//   stall_cnt            : cycles where the output is stalled (saturating)
//   busy                 : any sample in flight
module logicnet_pipe_ctrl
  import logicnet_pkg::*;
#(
  parameter int NUM_STAGES = LN_NUM_LAYERS,
  parameter int CNT_W      = 16,
  parameter int INF_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  input  logic                  cnt_clr,
  output logic [INF_W-1:0]      inflight,
  output logic [CNT_W-1:0]      sample_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  busy
);

  // Counters must not be wider than LN_SAT_W.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] val);
    return CNT_W'(sat_inc(LN_SAT_W'(val), LN_SAT_W'({CNT_W{1'b1}})));
  endfunction

  logic [NUM_STAGES-1:0] v;

  // The ready chain runs combinationally from out_ready back to in_ready.
  // Each stage keeps its own ready wire so that the chain is a plain ripple.
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    logic up_w;
    logic dn_rdy;
    logic rdy_w;

    if (i == 0) begin : g_first
      assign up_w = in_valid;
    end else begin : g_next
      assign up_w = v[i-1];
    end

    if (i == NUM_STAGES - 1) begin : g_last
      assign dn_rdy = out_ready;
    end else begin : g_mid
      assign dn_rdy = g_stage[i+1].rdy_w;
    end

    logicnet_stage_slot u_slot (
      .clk      (clk),
      .rst      (rst),
      .up_valid (up_w),
      .dn_ready (dn_rdy),
      .flush    (flush),
      .valid    (v[i]),
      .rdy      (rdy_w),
      .en       (stage_en[i])
    );
  end

  assign in_ready  = g_stage[0].rdy_w & ~flush;
  assign out_valid = v[NUM_STAGES-1];

  logic             accept;
  logic             out_hs;
  logic             stalled;
  logic [INF_W-1:0] inflight_q,   inflight_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;

  assign accept  = in_valid & in_ready;
  assign out_hs  = out_valid & out_ready;
  assign stalled = out_valid & ~out_ready;

  always_comb begin
    inflight_d = inflight_q;
    // Flush wins over everything. The output handshake in the flush cycle
    // still leaves the pipe, so 0 is correct in either case.
    if (flush) begin
      inflight_d = '0;
    end else if (accept && !out_hs) begin
      inflight_d = inflight_q + INF_W'(1);
    end else if (!accept && out_hs) begin
      inflight_d = inflight_q - INF_W'(1);
    end

    sample_cnt_d = sample_cnt_q;
    if (cnt_clr) begin
      sample_cnt_d = '0;
    end else if (out_hs) begin
      sample_cnt_d = cnt_inc(sample_cnt_q);
    end

    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (stalled) begin
      stall_cnt_d = cnt_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight_q   <= '0;
      sample_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      inflight_q   <= inflight_d;
      sample_cnt_q <= sample_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign inflight   = inflight_q;
  assign sample_cnt = sample_cnt_q;
  assign stall_cnt  = stall_cnt_q;
  assign busy       = (inflight_q != '0);

endmodule

// File: tb/tb_logicnet_pipe_ctrl.sv
// Directed bench for logicnet_pipe_ctrl. It runs a 4-stage instance with 4-bit
// counters and a 1-stage instance. Sample tags move through a bench-side data
// register model that is loaded by stage_en. A queue of accepted tags checks
// ordering, loss and duplication at the output.
module tb_logicnet_pipe_ctrl;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int IW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, flush, cnt_clr, busy;
  logic [N-1:0]  stage_en;
  logic [IW-1:0] inflight;
  logic [CW-1:0] sample_cnt, stall_cnt;

  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [0:0]    a_stage_en;
  logic [0:0]    a_inflight;
  logic [15:0]   a_sample_cnt, a_stall_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] in_data = 32'd100;
  logic [31:0] dp [N];
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  logicnet_pipe_ctrl #(.NUM_STAGES(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .stage_en(stage_en), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .cnt_clr(cnt_clr), .inflight(inflight),
    .sample_cnt(sample_cnt), .stall_cnt(stall_cnt), .busy(busy)
  );

  logicnet_pipe_ctrl #(.NUM_STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .stage_en(a_stage_en), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .flush(1'b0), .cnt_clr(1'b0), .inflight(a_inflight),
    .sample_cnt(a_sample_cnt), .stall_cnt(a_stall_cnt), .busy(a_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    #1;
    check("clr_sample", 32'(sample_cnt), 0);
    check("clr_stall", 32'(stall_cnt), 0);
  endtask

  // Scoreboard and data register model. Sampling happens on the falling edge,
  // where inputs and outputs are stable for the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
    end else begin
      check("inflight_vs_sb", 32'(inflight), 32'(sb.size()));
      check("inflight_vs_popcount", 32'(inflight), 32'($countones(dut.v)));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 1);
        end else begin
          check("out_tag", dp[N-1], sb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        check("accept_en0", 32'(stage_en[0]), 1);
        sb.push_back(in_data);
      end
      for (int i = N - 1; i >= 1; i--) begin
        if (stage_en[i]) dp[i] = dp[i-1];
      end
      if (stage_en[0]) dp[0] = in_data;
      if (in_valid && in_ready) in_data = in_data + 32'd1;
      if (flush) sb.delete();
    end
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0;

    // Reset state
    tick(); tick(); #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_inflight", 32'(inflight), 0);
    check("rst_sample", 32'(sample_cnt), 0);
    check("rst_stall", 32'(stall_cnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b1;
    tick();

    // Streaming
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("stream_in_ready", 32'(in_ready), 1);
      check("stream_out_valid", 32'(out_valid), (k >= 4) ? 1 : 0);
      check("stream_inflight", 32'(inflight), (k < 4) ? k : 4);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    #1;
    check("stream_sample", 32'(sample_cnt), 10);
    check("stream_stall", 32'(stall_cnt), 0);
    check("stream_drained", 32'(inflight), 0);
    clr_counts();

    // Backpressure
    in_valid = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), (k < 4) ? 1 : 0);
      check("bp_stage_en", 32'(stage_en), (k < 4) ? ((1 << (k + 1)) - 1) : 0);
      check("bp_out_valid", 32'(out_valid), (k >= 4) ? 1 : 0);
      tick();
    end
    #1;
    check("bp_stall", 32'(stall_cnt), 5);
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 1);
    for (int k = 0; k < 6; k++) begin
      check("bp_resume_out_valid", 32'(out_valid), 1);
      check("bp_resume_en", 32'(stage_en), 32'hF);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    #1;
    check("bp_sample", 32'(sample_cnt), 10);
    check("bp_stall_hold", 32'(stall_cnt), 5);
    check("bp_drained", 32'(inflight), 0);
    clr_counts();

    // Bubble collapse
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = (k == 0 || k == 2);
      #1;
      check("bub_in_ready", 32'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("bub_valids", 32'(dut.v), 32'hC);
    check("bub_inflight", 32'(inflight), 2);
    check("bub_in_ready_end", 32'(in_ready), 1);
    check("bub_out_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick(); tick(); #1;
    check("bub_sample", 32'(sample_cnt), 2);
    check("bub_drained", 32'(inflight), 0);
    clr_counts();

    // Flush with three samples in flight
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (3) tick();
    flush = 1'b1;
    #1;
    check("fl_inflight_before", 32'(inflight), 3);
    check("fl_in_ready", 32'(in_ready), 0);
    check("fl_stage_en", 32'(stage_en), 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("fl_inflight", 32'(inflight), 0);
    check("fl_busy", 32'(busy), 0);
    check("fl_valids", 32'(dut.v), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      check("fl_no_out_valid", 32'(out_valid), 0);
    end
    check("fl_sample", 32'(sample_cnt), 0);

    // Flush while the output handshake completes
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (5) tick();
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    #1;
    check("flhs_out_valid", 32'(out_valid), 1);
    tick();
    flush = 1'b0;
    #1;
    check("flhs_sample", 32'(sample_cnt), 1);
    check("flhs_inflight", 32'(inflight), 0);
    clr_counts();

    // Saturation and clear priority
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (24) tick();
    #1;
    check("sat_sample", 32'(sample_cnt), 15);
    check("sat_out_valid", 32'(out_valid), 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    #1;
    check("clr_over_hs", 32'(sample_cnt), 0);
    tick(); #1;
    check("after_clr_inc", 32'(sample_cnt), 1);
    in_valid = 1'b0;
    repeat (4) tick();

    // Reset while full and stalled
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (6) tick();
    #1;
    check("mr_full", 32'(inflight), 4);
    check("mr_stall_nonzero", 32'(stall_cnt != 0), 1);
    rst = 1'b0;
    tick();
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check("mr_valids", 32'(dut.v), 0);
    check("mr_inflight", 32'(inflight), 0);
    check("mr_sample", 32'(sample_cnt), 0);
    check("mr_stall", 32'(stall_cnt), 0);
    check("mr_out_valid", 32'(out_valid), 0);
    check("mr_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    tick();

    // Single-stage instance
    a_in_valid = 1'b1; a_out_ready = 1'b0;
    #1;
    check("s1_in_ready_empty", 32'(a_in_ready), 1);
    check("s1_en", 32'(a_stage_en), 1);
    tick();
    a_in_valid = 1'b0;
    #1;
    check("s1_out_valid", 32'(a_out_valid), 1);
    check("s1_in_ready_full", 32'(a_in_ready), 0);
    check("s1_busy", 32'(a_busy), 1);
    a_out_ready = 1'b1;
    #1;
    check("s1_in_ready_pass", 32'(a_in_ready), 1);
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    #1;
    check("s1_out_valid2", 32'(a_out_valid), 1);
    check("s1_inflight", 32'(a_inflight), 1);
    check("s1_sample1", 32'(a_sample_cnt), 1);
    tick(); #1;
    check("s1_empty", 32'(a_out_valid), 0);
    check("s1_inflight0", 32'(a_inflight), 0);
    check("s1_sample2", 32'(a_sample_cnt), 2);
    check("s1_stall", 32'(a_stall_cnt), 0);

    check("sb_empty_end", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logicnet_pipe_ctrl.md
Name: logicnet_pipe_ctrl

Overview:
- Elastic pipeline controller for the LogicNet classifier datapath: one register stage per neuron layer (layer0..layerN-1 LUT banks).
- Tracks a valid bit per stage and generates per-stage register load enables. Provides valid/ready handshakes at the feature input and the class output.
- Collapses bubbles, supports flush, and keeps throughput/stall statistics.
- Holds no datapath bits itself. The layer LUT modules stay purely combinational; this block only drives the enables of their output registers.

Parameters:
- NUM_STAGES, 4, number of layer register stages (≥1)
- CNT_W, 16, width of the sample and stall counters
- INF_W, $clog2(NUM_STAGES+1), width of the in-flight count (derived; do not override)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-low
- in_valid  in  1  feature vector present at layer0 inputs
- in_ready  out  1  controller accepts the feature vector this cycle
- stage_en  out  NUM_STAGES  load enable for layer i output register
- out_valid  out  1  final-layer register holds a result
- out_ready  in  1  consumer takes the result
- flush  in  1  discard all in-flight samples
- cnt_clr  in  1  zero sample_cnt and stall_cnt
- inflight  out  INF_W  number of valid stages
- sample_cnt  out  CNT_W  completed output handshakes, saturating
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- busy  out  1  inflight != 0

Behaviour:
- Reset (rst=0 at a clock edge): all stage valids, inflight, sample_cnt and stall_cnt go to 0. Reset mid-operation silently drops all samples.
- Per-stage valid v[i]. Define the ready chain:
  - rdy[NUM_STAGES] = out_ready
  - rdy[i] = ~v[i] | rdy[i+1]
  - This chain is combinational, with no registered path between out_ready and in_ready.
- Upstream valid: up[0] = in_valid; up[i] = v[i-1] for i>0.
- in_ready = rdy[0] & ~flush.
- stage_en[i] = rdy[i] & up[i] & ~flush. The datapath register loads only when a real sample moves in; it holds on bubbles to save toggling.
- Valid update when rdy[i]=1: v[i] <= up[i]. Otherwise v[i] holds.
- out_valid = v[NUM_STAGES-1].
- Latency: a sample accepted in cycle t (in_valid & in_ready) raises out_valid in cycle t+NUM_STAGES when unstalled. Throughput is 1 sample/cycle.
- Backpressure with out_ready=0: stages fill from the output backwards. in_ready drops only when all NUM_STAGES valids are set. Bubbles are absorbed.
- flush=1: all v[i] <= 0 and inflight <= 0. in_ready=0 and stage_en=0 in that cycle. An output handshake in the flush cycle still counts: out_valid & out_ready increments sample_cnt.
- inflight is a registered counter:
  - +1 on input accept, -1 on output handshake, unchanged when both occur.
  - Forced to 0 on flush.
  - Must always equal popcount(v) (bench assertion).
- sample_cnt increments on out_valid & out_ready. stall_cnt increments on out_valid & ~out_ready. Both saturate at 2^CNT_W-1.
- cnt_clr has priority over increment: the counter reads 0 on the next cycle. cnt_clr does not affect valids.
- NUM_STAGES=1 must work: in_ready = ~v[0] | out_ready.

Decomposition:
- Shared package logicnet_pkg:
  - LN_NUM_LAYERS constant, default for NUM_STAGES
  - sat_inc function (saturating increment, width-generic via parameterized wrapper)
- Sub-module logicnet_stage_slot: one valid bit plus its rdy/en logic (inputs up_valid, dn_ready, flush; outputs valid, rdy, en). Generated NUM_STAGES times.

Test Plan:
- Streaming: NUM_STAGES=4, in_valid=1 and out_ready=1 constantly for 10 cycles, first accept at t=2. Required: out_valid first at t=6, 10 handshakes, sample_cnt=10, inflight steady at 4, stall_cnt=0.
- Backpressure: stream with out_ready=0 from t=6. Required: in_ready=0 once 4 valids are set, stage_en=0, stall_cnt increments 1/cycle. On out_ready=1, one handshake per cycle resumes with no loss or duplication (scoreboard by sample tag).
- Bubble collapse: accept at t=0 only, out_ready=0, then a single in_valid at t=2. Required: both samples compact into stages 3 and 2, inflight=2, in_ready stays 1.
- Flush: 3 samples in flight, flush=1 for one cycle with in_valid=1. Required: next cycle inflight=0, busy=0, in_ready=0 and stage_en=0 during the flush cycle, and no out_valid afterwards.
- Saturation/clear: CNT_W=4, 20 handshakes. Required: sample_cnt=15. cnt_clr asserted together with a handshake gives sample_cnt=0.
- Reset mid-run: rst=0 for one cycle while full and stalled. Required: all valids, inflight, sample_cnt and stall_cnt = 0, out_valid=0, and in_ready=1 in the cycle after release.
